// File: rtl/atm_pkg.sv
// Shared types and encodings for the ATM session controller.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN_WAIT,
    ST_MENU,
    ST_EXEC,
    ST_EJECT
  } state_t;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  // Retry counter sized for the largest legal retry limit (7).
  localparam int unsigned MAX_TRIES_CAP = 7;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES_CAP + 1);

endpackage

// File: rtl/atm_idle_timer.sv
// Idle counter with synchronous clear, count enable and terminal-count flag.
module atm_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;

  // Flag rises on the TIMEOUT_CYC-th enabled cycle after a clear.
  assign expired = en && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_multi_session_ctrl.sv
// ATM session controller: account table, PIN check, service FSM and idle timeout.
// Optional per-session withdrawal cap enabled by defining ATM_SESSION_LIMIT_EN.
module atm_multi_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned NUM_ACCOUNTS = 8,
  parameter int unsigned CARD_W       = 6,
  parameter int unsigned PIN_W        = 16,
  parameter int unsigned BAL_W        = 20,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned INIT_BAL     = 1000
`ifdef ATM_SESSION_LIMIT_EN
  , parameter int unsigned SESSION_LIMIT = 500
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CARD_W-1:0] cfg_idx,
  input  logic [PIN_W-1:0]  cfg_pin,
  input  logic              card_in,
  input  logic [CARD_W-1:0] card_number,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [BAL_W-1:0]  amount,
  output logic              busy,
  output logic [BAL_W-1:0]  balance,
  output logic              op_done,
  output logic              error,
  output logic              wrong_pin,
  output logic              locked,
  output logic              card_out
);

  localparam int unsigned IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam logic [CARD_W:0]    NUM_ACC   = (CARD_W + 1)'(NUM_ACCOUNTS);
  localparam logic [TRY_W-1:0]   TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [BAL_W-1:0]   INIT_VAL  = BAL_W'(INIT_BAL);

  state_t state, state_d;

  logic [PIN_W-1:0]        pin_mem [NUM_ACCOUNTS];
  logic [BAL_W-1:0]        bal_mem [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q;

  logic [IDX_W-1:0] acct_q, idx_in, cfg_sel;
  logic [TRY_W-1:0] tries_q, tries_inc;
  logic [1:0]       op_q;
  logic [BAL_W-1:0] amt_q, balance_q, cur_bal, new_bal;
  logic [BAL_W:0]   dep_sum;

  logic op_done_q, error_q, wrong_pin_q, locked_q;
  logic op_done_d, error_d, wrong_pin_d, locked_d;
  logic card_ok, cfg_ok;
  logic accept_card, pin_ok, pin_bad, set_lock, latch_op, write_bal, strobe;
  logic timer_clr, timer_en, timeout;
  logic limit_hit;

`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W-1:0] wdr_total_q;
  logic [BAL_W:0]   wdr_sum;
  assign wdr_sum   = {1'b0, wdr_total_q} + {1'b0, amt_q};
  assign limit_hit = wdr_sum > (BAL_W + 1)'(SESSION_LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

  assign idx_in    = card_number[IDX_W-1:0];
  assign cfg_sel   = cfg_idx[IDX_W-1:0];
  assign card_ok   = {1'b0, card_number} < NUM_ACC;
  assign cfg_ok    = {1'b0, cfg_idx} < NUM_ACC;
  assign tries_inc = tries_q + TRY_W'(1);
  assign cur_bal   = bal_mem[acct_q];
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_q};
  assign timer_en  = (state == ST_PIN_WAIT) || (state == ST_MENU);

  always_comb begin
    state_d     = state;
    op_done_d   = 1'b0;
    error_d     = 1'b0;
    wrong_pin_d = 1'b0;
    locked_d    = 1'b0;
    accept_card = 1'b0;
    pin_ok      = 1'b0;
    pin_bad     = 1'b0;
    set_lock    = 1'b0;
    latch_op    = 1'b0;
    write_bal   = 1'b0;
    strobe      = 1'b0;
    new_bal     = cur_bal;
    unique case (state)
      ST_IDLE: begin
        if (card_in) begin
          if (!card_ok || lock_q[idx_in]) begin
            error_d = 1'b1;
            state_d = ST_EJECT;
          end else begin
            accept_card = 1'b1;
            state_d     = ST_PIN_WAIT;
          end
        end
      end
      ST_PIN_WAIT: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = ST_EJECT;
        end else if (pin_valid) begin
          strobe = 1'b1;
          if (pin == pin_mem[acct_q]) begin
            pin_ok  = 1'b1;
            state_d = ST_MENU;
          end else begin
            pin_bad     = 1'b1;
            wrong_pin_d = 1'b1;
            if (tries_inc == TRY_LIMIT) begin
              set_lock = 1'b1;
              locked_d = 1'b1;
              error_d  = 1'b1;
              state_d  = ST_EJECT;
            end
          end
        end
      end
      ST_MENU: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = ST_EJECT;
        end else if (op_valid) begin
          strobe = 1'b1;
          if (op == OP_END) begin
            state_d = ST_EJECT;
          end else begin
            latch_op = 1'b1;
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_MENU;
        unique case (op_q)
          OP_INQ: op_done_d = 1'b1;
          OP_DEP: begin
            if (dep_sum[BAL_W]) begin
              error_d = 1'b1;
            end else begin
              new_bal   = dep_sum[BAL_W-1:0];
              write_bal = 1'b1;
              op_done_d = 1'b1;
            end
          end
          OP_WDR: begin
            if ((amt_q > cur_bal) || limit_hit) begin
              error_d = 1'b1;
            end else begin
              new_bal   = cur_bal - amt_q;
              write_bal = 1'b1;
              op_done_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_EJECT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A wrong PIN that does not lock stays in PIN_WAIT, so strobes clear the timer too.
  assign timer_clr = (state_d != state) || strobe;

  atm_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_done_q   <= 1'b0;
      error_q     <= 1'b0;
      wrong_pin_q <= 1'b0;
      locked_q    <= 1'b0;
      balance_q   <= '0;
      acct_q      <= '0;
      tries_q     <= '0;
      op_q        <= '0;
      amt_q       <= '0;
      lock_q      <= '0;
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_mem[i] <= '0;
        bal_mem[i] <= INIT_VAL;
      end
`ifdef ATM_SESSION_LIMIT_EN
      wdr_total_q <= '0;
`endif
    end else begin
      state       <= state_d;
      op_done_q   <= op_done_d;
      error_q     <= error_d;
      wrong_pin_q <= wrong_pin_d;
      locked_q    <= locked_d;
      // The card check above reads the table before this write lands.
      if ((state == ST_IDLE) && cfg_we && cfg_ok) begin
        pin_mem[cfg_sel] <= cfg_pin;
        lock_q[cfg_sel]  <= 1'b0;
      end
      if (accept_card) begin
        acct_q  <= idx_in;
        tries_q <= '0;
      end
      if (pin_ok) balance_q <= bal_mem[acct_q];
      if (pin_bad) tries_q <= tries_inc;
      if (set_lock) lock_q[acct_q] <= 1'b1;
      if (latch_op) begin
        op_q  <= op;
        amt_q <= amount;
      end
      if (write_bal) begin
        bal_mem[acct_q] <= new_bal;
        balance_q       <= new_bal;
      end
`ifdef ATM_SESSION_LIMIT_EN
      if (accept_card) begin
        wdr_total_q <= '0;
      end else if (write_bal && (op_q == OP_WDR)) begin
        wdr_total_q <= wdr_sum[BAL_W-1:0];
      end
`endif
    end
  end

  assign busy      = (state != ST_IDLE);
  assign card_out  = (state == ST_EJECT);
  assign balance   = balance_q;
  assign op_done   = op_done_q;
  assign error     = error_q;
  assign wrong_pin = wrong_pin_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_atm_multi_session_ctrl.sv
// Scoreboard bench for atm_multi_session_ctrl: directed sessions, monitor pops expected events.
module tb_atm_multi_session_ctrl;

  localparam logic [1:0] INQ  = 2'b00;
  localparam logic [1:0] DEP  = 2'b01;
  localparam logic [1:0] WDR  = 2'b10;
  localparam logic [1:0] ENDS = 2'b11;

`ifdef ATM_SESSION_LIMIT_EN
  localparam logic [19:0] C4_BAL  = 20'd600;
  localparam logic        C4_OK   = 1'b0;
`else
  localparam logic [19:0] C4_BAL  = 20'd400;
  localparam logic        C4_OK   = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [5:0]  cfg_idx;
  logic [15:0] cfg_pin;
  logic        card_in;
  logic [5:0]  card_number;
  logic        pin_valid;
  logic [15:0] pin;
  logic        op_valid;
  logic [1:0]  op;
  logic [19:0] amount;
  logic        busy;
  logic [19:0] balance;
  logic        op_done, error, wrong_pin, locked, card_out;

  always #5 clk = ~clk;

  atm_multi_session_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_pin     (cfg_pin),
    .card_in     (card_in),
    .card_number (card_number),
    .pin_valid   (pin_valid),
    .pin         (pin),
    .op_valid    (op_valid),
    .op          (op),
    .amount      (amount),
    .busy        (busy),
    .balance     (balance),
    .op_done     (op_done),
    .error       (error),
    .wrong_pin   (wrong_pin),
    .locked      (locked),
    .card_out    (card_out)
  );

  typedef struct packed {
    logic        op_done;
    logic        error;
    logic        wrong_pin;
    logic        locked;
    logic        card_out;
    logic [19:0] bal;
  } ev_t;

  ev_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic push(input logic d, input logic e, input logic w, input logic l,
                      input logic c, input logic [19:0] b);
    ev_t ev;
    ev = '{op_done: d, error: e, wrong_pin: w, locked: l, card_out: c, bal: b};
    sb.push_back(ev);
  endtask

  task automatic monitor_loop();
    ev_t got, exp;
    forever begin
      @(negedge clk);
      if (!rst && (op_done || error || wrong_pin || locked || card_out)) begin
        got = {op_done, error, wrong_pin, locked, card_out, balance};
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event: got od=%b er=%b wp=%b lk=%b co=%b bal=%0d, none required",
                   got.op_done, got.error, got.wrong_pin, got.locked, got.card_out, got.bal);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            mismatched++;
            $display("FAIL event: got od=%b er=%b wp=%b lk=%b co=%b bal=%0d, required od=%b er=%b wp=%b lk=%b co=%b bal=%0d",
                     got.op_done, got.error, got.wrong_pin, got.locked, got.card_out, got.bal,
                     exp.op_done, exp.error, exp.wrong_pin, exp.locked, exp.card_out, exp.bal);
          end
        end
      end
    end
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: %0d events still pending after %0d cycles, required 0", name, sb.size(), bound);
      sb.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_card(input logic [5:0] n);
    cyc(); card_in = 1'b1; card_number = n;
    cyc(); card_in = 1'b0;
  endtask

  task automatic do_pin(input logic [15:0] p);
    cyc(); pin_valid = 1'b1; pin = p;
    cyc(); pin_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [19:0] a);
    cyc(); op_valid = 1'b1; op = o; amount = a;
    cyc(); op_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [5:0] idx, input logic [15:0] p);
    cyc(); cfg_we = 1'b1; cfg_idx = idx; cfg_pin = p;
    cyc(); cfg_we = 1'b0;
  endtask

  task automatic do_cfg_card(input logic [5:0] idx, input logic [15:0] p, input logic [5:0] n);
    cyc(); cfg_we = 1'b1; cfg_idx = idx; cfg_pin = p; card_in = 1'b1; card_number = n;
    cyc(); cfg_we = 1'b0; card_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_pin = '0; card_in = 1'b0; card_number = '0;
    pin_valid = 1'b0; pin = '0; op_valid = 1'b0; op = '0; amount = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) cyc();
    check("reset_flags", {26'd0, busy, op_done, error, wrong_pin, locked, card_out}, 32'd0);
    check("reset_balance", {12'd0, balance}, 32'd0);
    rst = 1'b0;

    // Normal session on card 2 with a configured PIN
    do_cfg(6'd2, 16'h1234);
    do_card(6'd2);
    check("busy_after_card", {31'd0, busy}, 32'd1);
    do_pin(16'h1234);
    check("bal_after_pin", {12'd0, balance}, 32'd1000);
    push(1, 0, 0, 0, 0, 20'd700); do_op(WDR, 20'd300);
    push(0, 0, 0, 0, 1, 20'd700); do_op(ENDS, 20'd0);
    drain("session1", 10);
    cyc();
    check("busy_after_end", {31'd0, busy}, 32'd0);

    // Three wrong PINs lock card 2; reinsert is rejected
    do_card(6'd2);
    push(0, 0, 1, 0, 0, 20'd700); do_pin(16'h0001);
    push(0, 0, 1, 0, 0, 20'd700); do_pin(16'h0002);
    push(0, 1, 1, 1, 1, 20'd700); do_pin(16'h0003);
    drain("lockout", 10);
    cyc();
    check("busy_after_lock", {31'd0, busy}, 32'd0);
    push(0, 1, 0, 0, 1, 20'd700); do_card(6'd2);
    drain("locked_reinsert", 10);
    // cfg and card in the same cycle: card sees the old (locked) entry
    push(0, 1, 0, 0, 1, 20'd700); do_cfg_card(6'd2, 16'h4321, 6'd2);
    drain("cfg_with_card", 10);
    cyc();
    check("busy_after_cfg_card", {31'd0, busy}, 32'd0);
    do_card(6'd2);
    do_pin(16'h4321);
    check("bal_card2_unlocked", {12'd0, balance}, 32'd700);
    push(0, 0, 0, 0, 1, 20'd700); do_op(ENDS, 20'd0);
    drain("session2", 10);

    // Bounds: overdraft, overflow, zero amounts, exact fill to max
    do_card(6'd3);
    do_pin(16'h0000);
    check("bal_card3", {12'd0, balance}, 32'd1000);
    push(0, 1, 0, 0, 0, 20'd1000);    do_op(WDR, 20'd1001);
    push(0, 1, 0, 0, 0, 20'd1000);    do_op(DEP, 20'd1047576);
    push(1, 0, 0, 0, 0, 20'd1000);    do_op(WDR, 20'd0);
    push(1, 0, 0, 0, 0, 20'd1005);    do_op(DEP, 20'd5);
    push(1, 0, 0, 0, 0, 20'd1005);    do_op(INQ, 20'd0);
    push(1, 0, 0, 0, 0, 20'hFFFFF);   do_op(DEP, 20'd1047570);
    push(0, 0, 0, 0, 1, 20'hFFFFF);   do_op(ENDS, 20'd0);
    drain("bounds", 20);

    // Two withdrawals on card 4; second is capped when the session limit is built in
    do_card(6'd4);
    do_pin(16'h0000);
    push(1, 0, 0, 0, 0, 20'd600);     do_op(WDR, 20'd400);
    push(C4_OK, !C4_OK, 0, 0, 0, C4_BAL); do_op(WDR, 20'd200);
    push(0, 0, 0, 0, 1, C4_BAL);      do_op(ENDS, 20'd0);
    drain("session_limit", 20);

    // Out-of-range card, then MENU timeout with an ignored cfg write in between
    push(0, 1, 0, 0, 1, C4_BAL); do_card(6'd9);
    drain("bad_card", 10);
    do_card(6'd5);
    do_pin(16'h0000);
    check("bal_card5", {12'd0, balance}, 32'd1000);
    do_cfg(6'd5, 16'h5555);
    push(0, 1, 0, 0, 1, 20'd1000);
    drain("menu_timeout", 1100);
    cyc();
    check("busy_after_timeout", {31'd0, busy}, 32'd0);

    // Reset mid-session restores balances, PINs and locks without ejecting
    do_card(6'd5);
    do_pin(16'h0000);
    check("cfg_ignored_bal", {12'd0, balance}, 32'd1000);
    push(1, 0, 0, 0, 0, 20'd1010); do_op(DEP, 20'd10);
    drain("pre_reset_dep", 10);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    check("midreset_flags", {26'd0, busy, op_done, error, wrong_pin, locked, card_out}, 32'd0);
    check("midreset_balance", {12'd0, balance}, 32'd0);
    do_card(6'd5);
    do_pin(16'h0000);
    check("bal_card5_after_rst", {12'd0, balance}, 32'd1000);
    push(0, 0, 0, 0, 1, 20'd1000); do_op(ENDS, 20'd0);
    drain("post_reset5", 10);
    do_card(6'd2);
    do_pin(16'h0000);
    check("bal_card2_after_rst", {12'd0, balance}, 32'd1000);
    push(0, 0, 0, 0, 1, 20'd1000); do_op(ENDS, 20'd0);
    drain("post_reset2", 10);

    repeat (5) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
